up_dn_counter_ctrl: RTL and testbench

Sequencing controller that drives an up/down counter through its Load/Up/Down/IN inputs and monitors its Counter/High/Low outputs. On a Start command it loads a start value, steps the counter one count per cycle toward a target, stops exactly on the target, and reports completion, step count and a stuck-counter error. It is the command side of the counter interface and replaces hand-driven stimulus in the system.

---
 rtl/up_dn_counter_ctrl.sv | 159 +++++++++++++++
 tb/tb_up_dn_counter_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/up_dn_counter_ctrl.sv
// Sequencer that loads an up/down counter, steps it to a target and reports Done/Steps/Err.
// Define UP_DN_CTRL_PINGPONG_EN to add a return leg back to the start value before Done.
module up_dn_counter_ctrl #(
   parameter int WIDTH = 5
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Start,
   input  logic [WIDTH-1:0] Start_Val,
   input  logic [WIDTH-1:0] Target,
   input  logic [WIDTH-1:0] Counter,
   input  logic             High,
   input  logic             Low,
   output logic             Load,
   output logic [WIDTH-1:0] IN,
   output logic             Up,
   output logic             Down,
   output logic             Busy,
   output logic             Done,
   output logic             Err,
   output logic [WIDTH:0]   Steps
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE,
      S_ERR
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] start_q, start_d;
   logic [WIDTH-1:0] target_q, target_d;
   logic [WIDTH-1:0] tmo_q, tmo_d;
   logic [WIDTH:0]   steps_q, steps_d;
   logic             dir_up_q, dir_up_d;
   logic             dir_dn_q, dir_dn_d;
   logic [WIDTH-1:0] goal;
   logic             at_goal;
`ifdef UP_DN_CTRL_PINGPONG_EN
   logic             leg_q, leg_d;
`endif

   always_comb begin
      state_d  = state_q;
      start_d  = start_q;
      target_d = target_q;
      tmo_d    = tmo_q;
      steps_d  = steps_q;
      dir_up_d = dir_up_q;
      dir_dn_d = dir_dn_q;
`ifdef UP_DN_CTRL_PINGPONG_EN
      leg_d    = leg_q;
`endif
      Load     = 1'b0;
      IN       = '0;
      Up       = 1'b0;
      Down     = 1'b0;
      Busy     = 1'b0;
      Done     = 1'b0;
      Err      = 1'b0;

      goal = target_q;
`ifdef UP_DN_CTRL_PINGPONG_EN
      if (leg_q) begin
         goal = start_q;
      end
`endif
      at_goal = (Counter == goal);

      case (state_q)
         S_IDLE, S_ERR: begin
            Err = (state_q == S_ERR);
            if (Start) begin
               start_d  = Start_Val;
               target_d = Target;
               steps_d  = '0;
               state_d  = S_LOAD;
            end
         end
         S_LOAD: begin
            Load     = 1'b1;
            IN       = start_q;
            Busy     = 1'b1;
            dir_up_d = (target_q > start_q);
            dir_dn_d = (target_q < start_q);
            tmo_d    = '0;
`ifdef UP_DN_CTRL_PINGPONG_EN
            leg_d    = 1'b0;
`endif
            state_d  = S_RUN;
         end
         S_RUN: begin
            Busy = 1'b1;
            // Gated on the live counter value so the step stops in the cycle it lands.
            Up   = dir_up_q && !at_goal && !High;
            Down = dir_dn_q && !at_goal && !Low;
            if (Up || Down) begin
               steps_d = steps_q + 1'b1;
            end
            if (at_goal) begin
`ifdef UP_DN_CTRL_PINGPONG_EN
               if (!leg_q) begin
                  leg_d    = 1'b1;
                  dir_up_d = dir_dn_q;
                  dir_dn_d = dir_up_q;
                  tmo_d    = '0;
               end else begin
                  state_d = S_DONE;
               end
`else
               state_d = S_DONE;
`endif
            end else if (tmo_q == '1) begin
               state_d = S_ERR;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_DONE: begin
            Done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign Steps = steps_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= S_IDLE;
         start_q  <= '0;
         target_q <= '0;
         tmo_q    <= '0;
         steps_q  <= '0;
         dir_up_q <= 1'b0;
         dir_dn_q <= 1'b0;
`ifdef UP_DN_CTRL_PINGPONG_EN
         leg_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         start_q  <= start_d;
         target_q <= target_d;
         tmo_q    <= tmo_d;
         steps_q  <= steps_d;
         dir_up_q <= dir_up_d;
         dir_dn_q <= dir_dn_d;
`ifdef UP_DN_CTRL_PINGPONG_EN
         leg_q    <= leg_d;
`endif
      end
   end

endmodule

// File: tb/tb_up_dn_counter_ctrl.sv
// Bench for up_dn_counter_ctrl: saturating counter model plus expected-result queue
// checked by a monitor on each Done pulse or Err rise.
module tb_up_dn_counter_ctrl;
   localparam int W = 5;
`ifdef UP_DN_CTRL_PINGPONG_EN
   localparam bit PP = 1'b1;
`else
   localparam bit PP = 1'b0;
`endif

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         Start = 1'b0;
   logic [W-1:0] Start_Val = '0;
   logic [W-1:0] Target = '0;
   logic [W-1:0] Counter;
   logic         High, Low;
   logic         Load, Up, Down, Busy, Done, Err;
   logic [W-1:0] IN;
   logic [W:0]   Steps;

   logic [W-1:0] cnt = '0;
   logic         stuck = 1'b0;

   assign Counter = cnt;
   assign High    = &cnt;
   assign Low     = (cnt == '0);

   always #5 CLK = ~CLK;

   up_dn_counter_ctrl #(.WIDTH(W)) dut (
      .CLK(CLK), .RST(RST), .Start(Start), .Start_Val(Start_Val), .Target(Target),
      .Counter(Counter), .High(High), .Low(Low), .Load(Load), .IN(IN), .Up(Up),
      .Down(Down), .Busy(Busy), .Done(Done), .Err(Err), .Steps(Steps)
   );

   // Controlled counter: Load beats Down beats Up, saturating; stuck ignores steps.
   always @(posedge CLK) begin
      if (Load) cnt <= IN;
      else if (!stuck) begin
         if (Down) begin
            if (cnt != '0) cnt <= cnt - 1'b1;
         end else if (Up) begin
            if (cnt != '1) cnt <= cnt + 1'b1;
         end
      end
   end

   typedef struct {
      int kind;   // 0 = Done expected, 1 = Err expected
      int start;
      int steps;
      int ups;
      int dns;
      int fin;
      int lat;    // Load-to-Done cycles, -1 when not checked
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   evt_cnt = 0;

   task automatic chk(input string nm, input int act, input int req);
      n_chk++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
   endtask

   initial begin : mon
      int   cyc;
      int   ups;
      int   dns;
      int   both;
      bit   err_prev;
      exp_t e;
      cyc = 0; ups = 0; dns = 0; both = 0; err_prev = 1'b0;
      forever begin
         @(negedge CLK);
         if (RST) begin
            err_prev = 1'b0;
         end else begin
            if (Load) begin
               cyc = 0; ups = 0; dns = 0; both = 0;
               chk("load_err_clear", Err, 0);
               if (exp_q.size() != 0) chk("load_in", IN, exp_q[0].start);
            end else begin
               cyc++;
            end
            if (Up) ups++;
            if (Down) dns++;
            if (Up && Down) both++;
            if (Done) begin
               evt_cnt++;
               chk("done_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("done_kind", 0, e.kind);
                  chk("done_steps", Steps, e.steps);
                  chk("done_up_cycles", ups, e.ups);
                  chk("done_down_cycles", dns, e.dns);
                  chk("up_down_overlap", both, 0);
                  chk("done_counter", Counter, e.fin);
                  chk("done_busy", Busy, 0);
                  if (e.lat >= 0) chk("done_latency", cyc, e.lat);
               end
            end
            if (Err && !err_prev) begin
               evt_cnt++;
               chk("err_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("err_kind", 1, e.kind);
                  chk("err_up_cycles", ups, e.ups);
                  chk("err_up_low", Up, 0);
                  chk("err_busy", Busy, 0);
                  chk("err_steps", Steps, e.steps);
               end
            end
            err_prev = Err;
         end
      end
   end

   task automatic run_op(input int sv, input int tg, input int kind, input int ups,
                         input int dns, input int steps, input int fin, input int lat,
                         input bit extra);
      exp_t e;
      int   base;
      bit   seen;
      e = '{kind, sv, steps, ups, dns, fin, lat};
      exp_q.push_back(e);
      base = evt_cnt;
      @(posedge CLK); #1;
      Start = 1'b1; Start_Val = W'(sv); Target = W'(tg);
      @(posedge CLK); #1;
      if (extra) begin
         // Held through LOAD, RUN and DONE with different values: must be ignored.
         Start_Val = 5'd1; Target = 5'd30;
         repeat (3) @(posedge CLK);
         #1;
      end
      Start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (evt_cnt != base) begin
            seen = 1'b1;
            break;
         end
         @(negedge CLK);
      end
      chk("event_seen", seen, 1);
      repeat (2) @(negedge CLK);
      chk("steps_hold", Steps, steps);
   endtask

   initial begin
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_load", Load, 0);
      chk("rst_up", Up, 0);
      chk("rst_down", Down, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_done", Done, 0);
      chk("rst_err", Err, 0);
      chk("rst_in", IN, 0);
      chk("rst_steps", Steps, 0);
      @(posedge CLK); #1 RST = 1'b0;

      run_op(4, 0, 0, PP ? 4 : 0, 4, PP ? 8 : 4, PP ? 4 : 0, -1, 1'b0);
      run_op(26, 31, 0, 5, PP ? 5 : 0, PP ? 10 : 5, PP ? 26 : 31, -1, 1'b0);
      run_op(9, 9, 0, 0, 0, 0, 9, PP ? 3 : 2, 1'b1);

      // Reset in the middle of a 2 -> 20 run.
      @(posedge CLK); #1;
      Start = 1'b1; Start_Val = 5'd2; Target = 5'd20;
      @(posedge CLK); #1 Start = 1'b0;
      repeat (5) @(posedge CLK);
      @(negedge CLK);
      chk("pre_rst_up", Up, 1);
      #1 RST = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      chk("midrst_up", Up, 0);
      chk("midrst_down", Down, 0);
      chk("midrst_load", Load, 0);
      chk("midrst_busy", Busy, 0);
      chk("midrst_steps", Steps, 0);
      @(posedge CLK); #1 RST = 1'b0;
      run_op(2, 20, 0, 18, PP ? 18 : 0, PP ? 36 : 18, PP ? 2 : 20, -1, 1'b0);

      // Counter frozen at 3: timeout after 32 RUN cycles, then Start recovers.
      stuck = 1'b1;
      run_op(3, 10, 1, 32, 0, 32, 3, -1, 1'b0);
      @(negedge CLK);
      chk("err_held", Err, 1);
      stuck = 1'b0;
      run_op(3, 10, 0, 7, PP ? 7 : 0, PP ? 14 : 7, PP ? 3 : 10, -1, 1'b0);

`ifdef UP_DN_CTRL_PINGPONG_EN
      run_op(10, 13, 0, 3, 3, 6, 10, -1, 1'b0);
`endif

      repeat (4) @(negedge CLK);
      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish within 200000 time units");
      $fatal(1);
   end

endmodule
